// File: rtl/a2_rot_pipe.sv
// a2_rot_pipe: registered per-nibble bit rotation stage for the shared Midori64
// S-box datapath. Every nibble of every share is rotated by the same runtime
// amount/direction, so the map stays share-wise linear and needs no randomness.
// Words are rotated on the way in and stored already rotated in a 2-entry
// buffer, so the output side is a plain register read with no logic after the
// flops.
//
// state (count_q) | meaning
// ----------------+-----------------------------------------------
// 0               | buffer empty, out_valid low
// 1               | head holds the oldest word
// 2               | head and tail full, in_ready low
module a2_rot_pipe #(
  parameter  int SHARES  = 3,
  parameter  int NIBBLES = 16,
  parameter  int NW      = 4,
  localparam int ROT_W   = $clog2(NW),
  localparam int DW      = SHARES * NIBBLES * NW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [ROT_W-1:0] in_rot,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [DW-1:0] rot_data;
  logic          push, pop;

  // Rotating the doubled nibble lets one shift cover both halves of the rotation.
  function automatic logic [NW-1:0] rot_nib(input logic [NW-1:0]    x,
                                            input logic [ROT_W-1:0] r,
                                            input logic             dir);
    logic [2*NW-1:0] dbl;
    dbl = {x, x};
    if (!dir) begin
      dbl = dbl >> r;
      return dbl[NW-1:0];
    end else begin
      dbl = dbl << r;
      return dbl[2*NW-1:NW];
    end
  endfunction

  // Same rotation applied to every nibble of every share; shares never mix.
  always_comb begin
    rot_data = '0;
    for (int i = 0; i < SHARES * NIBBLES; i++) begin
      rot_data[i*NW +: NW] = rot_nib(in_data[i*NW +: NW], in_rot, in_dir);
    end
  end

  // Handshake flags come straight from registers.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != CNT_EMPTY);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state for the 2-entry buffer; push+pop at one entry replaces the head.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      CNT_EMPTY: begin
        if (push) begin
          head_d  = rot_data;
          count_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (push && pop) begin
          head_d = rot_data;
        end else if (push) begin
          tail_d  = rot_data;
          count_d = CNT_FULL;
        end else if (pop) begin
          count_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = CNT_ONE;
        end
      end
      default: count_d = CNT_EMPTY;
    endcase
  end

  // State and data registers; reset wipes stored shares as well as the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CNT_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_a2_rot_pipe.sv
// Directed and scoreboarded checks for a2_rot_pipe at default parameters.
module tb_a2_rot_pipe;

  localparam int SHARES  = 3;
  localparam int NIBBLES = 16;
  localparam int NW      = 4;
  localparam int NNIB    = SHARES * NIBBLES;
  localparam int DW      = SHARES * NIBBLES * NW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_rot;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int n_cmp;
  int n_err;

  a2_rot_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rot    (in_rot),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fill(input logic [3:0] v);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < NNIB; i++) w[i*NW +: NW] = v;
    return w;
  endfunction

  // Reference rotation, bit-index form: right moves bit (i+r) to i.
  function automatic logic [DW-1:0] model_rot(input logic [DW-1:0] w,
                                              input logic [1:0] r,
                                              input logic dir);
    logic [DW-1:0] o;
    int src;
    o = '0;
    for (int n = 0; n < NNIB; n++) begin
      for (int b = 0; b < NW; b++) begin
        if (!dir) src = (b + int'(r)) % NW;
        else      src = (b - int'(r) + NW) % NW;
        o[n*NW + b] = w[n*NW + src];
      end
    end
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [1:0] r,
                       input logic dir, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_rot    = r;
    in_dir    = dir;
    out_ready = ordy;
  endtask

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] w0, w1, w2, mixed, wr;
  logic [1:0]    rr;
  logic          rd, rv, ro, do_push, do_pop;
  int            sent, recv, cyc;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // A2 direction: 0001 -> 1000, then 0110 -> 0011 with push+pop at one entry
    drive(1'b1, fill(4'h1), 2'd1, 1'b0, 1'b1);
    step();
    check("a2_valid", out_valid, 1);
    check("a2_0001", out_data, fill(4'h8));
    drive(1'b1, fill(4'h6), 2'd1, 1'b0, 1'b1);
    step();
    check("a2_0110", out_data, fill(4'h3));
    check("a2_ready", in_ready, 1);
    drive(1'b1, fill(4'h8), 2'd1, 1'b1, 1'b1);
    step();
    check("left1_1000", out_data, fill(4'h1));
    drive(1'b1, fill(4'hA), 2'd0, 1'b0, 1'b1);
    step();
    check("r0_ident", out_data, fill(4'hA));
    drive(1'b1, fill(4'h8), 2'd2, 1'b0, 1'b1);
    step();
    check("r2_right", out_data, fill(4'h2));
    drive(1'b1, fill(4'h8), 2'd2, 1'b1, 1'b1);
    step();
    check("r2_left", out_data, fill(4'h2));
    // nibble i holds i; right by 3 on 0x1 -> 0x2, 0x3 -> 0x6, 0x9 -> 0x3
    mixed = '0;
    for (int i = 0; i < NNIB; i++) mixed[i*NW +: NW] = 4'(i);
    drive(1'b1, mixed, 2'd3, 1'b0, 1'b1);
    step();
    check("mix_n1", out_data[1*NW +: NW], 4'h2);
    check("mix_n3", out_data[3*NW +: NW], 4'h6);
    check("mix_n9", out_data[9*NW +: NW], 4'h3);
    drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
    step();
    check("drain_valid", out_valid, 0);

    // back-pressure: fill both entries, then blocked push
    w0 = fill(4'h1);
    w1 = fill(4'h2);
    w2 = fill(4'h3);
    drive(1'b1, w0, 2'd0, 1'b0, 1'b0);
    step();
    check("bp_ready1", in_ready, 1);
    check("bp_w0", out_data, w0);
    drive(1'b1, w1, 2'd0, 1'b0, 1'b0);
    step();
    check("bp_full", in_ready, 0);
    check("bp_w0_hold", out_data, w0);
    drive(1'b1, fill(4'hF), 2'd0, 1'b0, 1'b0);
    step();
    check("bp_w0_stable", out_data, w0);
    check("bp_still_full", in_ready, 0);
    // pop at full with in_valid high: no push may happen
    drive(1'b1, fill(4'hF), 2'd0, 1'b0, 1'b1);
    step();
    check("pop_w1", out_data, w1);
    check("pop_ready", in_ready, 1);
    // count=1: push W2 and pop W1 together
    drive(1'b1, w2, 2'd0, 1'b0, 1'b1);
    step();
    check("pp_w2", out_data, w2);
    check("pp_valid", out_valid, 1);
    drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
    step();
    check("pp_empty", out_valid, 0);

    // random stream against scoreboard
    sent = 0;
    recv = 0;
    cyc  = 0;
    while ((sent < 100 || sb_q.size() != 0) && cyc < 3000) begin
      check("rs_valid", out_valid, (sb_q.size() != 0));
      check("rs_ready", in_ready, (sb_q.size() != 2));
      if (sb_q.size() != 0) check("rs_data", out_data, sb_q[0]);
      wr = rand_word();
      rr = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      rv = (sent < 100) && ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 2) != 0);
      drive(rv, wr, rr, rd, ro);
      do_push = rv && (sb_q.size() != 2);
      do_pop  = ro && (sb_q.size() != 0);
      step();
      if (do_pop) begin
        void'(sb_q.pop_front());
        recv++;
      end
      if (do_push) begin
        sb_q.push_back(model_rot(wr, rr, rd));
        sent++;
      end
      cyc++;
    end
    check("rs_recv", recv, 100);

    // async reset with both entries full
    drive(1'b1, w0, 2'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, w1, 2'd0, 1'b0, 1'b0);
    step();
    check("ar_full", in_ready, 0);
    drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, fill(4'h1), 2'd1, 1'b0, 1'b1);
    step();
    check("ar_first", out_data, fill(4'h8));
    drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
    step();
    check("ar_no_stale", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
